// File: rtl/sram_multibank_controller.sv
// Wishbone-classic slave in front of NUM_BANKS asynchronous SRAM chips that share one
// addr/data/oe/we/be bus, each with its own chip enable, using programmable access timing.
module sram_multibank_controller #(
   parameter int DATA_WIDTH      = 32,
   parameter int ADDR_WIDTH      = 32,
   parameter int SRAM_ADDR_WIDTH = 20,
   parameter int SRAM_DATA_WIDTH = 32,
   parameter int NUM_BANKS       = 2,
   parameter int READ_WAIT       = 2,
   parameter int WR_SETUP        = 1,
   parameter int WR_PULSE        = 1
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [ADDR_WIDTH-1:0]         wb_adr_i,
   input  logic [DATA_WIDTH-1:0]         wb_dat_i,
   output logic [DATA_WIDTH-1:0]         wb_dat_o,
   input  logic                          wb_we_i,
   input  logic [DATA_WIDTH/8-1:0]       wb_sel_i,
   input  logic                          wb_stb_i,
   input  logic                          wb_cyc_i,
   output logic                          wb_ack_o,
   output logic                          wb_err_o,
   output logic [SRAM_ADDR_WIDTH-1:0]    sram_addr,
   inout  wire  [SRAM_DATA_WIDTH-1:0]    sram_data,
   output logic [NUM_BANKS-1:0]          sram_ce_n,
   output logic                          sram_oe_n,
   output logic                          sram_we_n,
   output logic [SRAM_DATA_WIDTH/8-1:0]  sram_be_n
);

   localparam int SRAM_BYTES = SRAM_DATA_WIDTH / 8;
   localparam int BYTE_W     = (SRAM_BYTES > 1) ? $clog2(SRAM_BYTES) : 0;
   localparam int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
   localparam int MAX_WAIT_A = (READ_WAIT > WR_SETUP) ? READ_WAIT : WR_SETUP;
   localparam int MAX_WAIT   = (MAX_WAIT_A > WR_PULSE) ? MAX_WAIT_A : WR_PULSE;
   localparam int CNT_W      = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

   typedef enum logic [2:0] {
      IDLE,
      RD_WAIT,
      WR_SETUP_S,
      WR_PULSE_S,
      WR_HOLD,
      DONE
   } state_t;

   state_t                      state_q, state_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic                        ack_q, ack_d;
   logic                        err_q, err_d;
   logic [DATA_WIDTH-1:0]       dat_q, dat_d;
   logic [SRAM_ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [NUM_BANKS-1:0]        ce_n_q, ce_n_d;
   logic                        oe_n_q, oe_n_d;
   logic                        we_n_q, we_n_d;
   logic [SRAM_BYTES-1:0]       be_n_q, be_n_d;
   logic                        drive_q, drive_d;
   logic [SRAM_DATA_WIDTH-1:0]  wdata_q, wdata_d;

   logic [SRAM_ADDR_WIDTH-1:0]  req_word;
   logic [BANK_W-1:0]           req_bank;
   logic [BANK_W:0]             req_bank_ext;
   logic                        bank_ok;
   logic [NUM_BANKS-1:0]        req_ce_n;
   logic                        unused_adr;

   assign req_word     = wb_adr_i[BYTE_W +: SRAM_ADDR_WIDTH];
   assign req_bank     = wb_adr_i[BYTE_W + SRAM_ADDR_WIDTH +: BANK_W];
   assign req_bank_ext = {1'b0, req_bank};
   assign bank_ok      = req_bank_ext < (BANK_W + 1)'(NUM_BANKS);
   assign unused_adr   = ^wb_adr_i;

   always_comb begin
      req_ce_n = '1;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (req_bank == BANK_W'(b)) begin
            req_ce_n[b] = 1'b0;
         end
      end
   end

   // Each access runs to completion on the SRAM side; a dropped cyc_i only suppresses the ack.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ack_d   = ack_q;
      err_d   = err_q;
      dat_d   = dat_q;
      addr_d  = addr_q;
      ce_n_d  = ce_n_q;
      oe_n_d  = oe_n_q;
      we_n_d  = we_n_q;
      be_n_d  = be_n_q;
      drive_d = drive_q;
      wdata_d = wdata_q;
      case (state_q)
         IDLE: begin
            if (wb_stb_i && wb_cyc_i) begin
               if (!bank_ok) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  addr_d = req_word;
                  be_n_d = ~wb_sel_i;
                  ce_n_d = req_ce_n;
                  if (wb_we_i) begin
                     drive_d = 1'b1;
                     wdata_d = wb_dat_i;
                     cnt_d   = CNT_W'(WR_SETUP - 1);
                     state_d = WR_SETUP_S;
                  end else begin
                     oe_n_d  = 1'b0;
                     cnt_d   = CNT_W'(READ_WAIT - 1);
                     state_d = RD_WAIT;
                  end
               end
            end
         end
         RD_WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               if (wb_cyc_i) begin
                  dat_d = sram_data;
                  ack_d = 1'b1;
               end
               ce_n_d  = '1;
               oe_n_d  = 1'b1;
               be_n_d  = '1;
               state_d = DONE;
            end
         end
         WR_SETUP_S: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               we_n_d  = 1'b0;
               cnt_d   = CNT_W'(WR_PULSE - 1);
               state_d = WR_PULSE_S;
            end
         end
         WR_PULSE_S: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               we_n_d  = 1'b1;
               state_d = WR_HOLD;
            end
         end
         WR_HOLD: begin
            if (wb_cyc_i) begin
               ack_d = 1'b1;
            end
            ce_n_d  = '1;
            be_n_d  = '1;
            state_d = DONE;
         end
         DONE: begin
            ack_d   = 1'b0;
            err_d   = 1'b0;
            drive_d = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         dat_q   <= '0;
         addr_q  <= '0;
         ce_n_q  <= '1;
         oe_n_q  <= 1'b1;
         we_n_q  <= 1'b1;
         be_n_q  <= '1;
         drive_q <= 1'b0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         dat_q   <= dat_d;
         addr_q  <= addr_d;
         ce_n_q  <= ce_n_d;
         oe_n_q  <= oe_n_d;
         we_n_q  <= we_n_d;
         be_n_q  <= be_n_d;
         drive_q <= drive_d;
         wdata_q <= wdata_d;
      end
   end

   assign sram_data = drive_q ? wdata_q : {SRAM_DATA_WIDTH{1'bz}};
   assign wb_dat_o  = dat_q;
   assign wb_ack_o  = ack_q;
   assign wb_err_o  = err_q;
   assign sram_addr = addr_q;
   assign sram_ce_n = ce_n_q;
   assign sram_oe_n = oe_n_q;
   assign sram_we_n = we_n_q;
   assign sram_be_n = be_n_q;

endmodule

// File: tb/tb_sram_multibank_controller.sv
// Bench for sram_multibank_controller: instance A uses default timing with two banks,
// instance B uses three banks with stretched timing; both sit on simple SRAM chip models.
module tb_sram_multibank_controller;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [31:0] wb_adr [2];
   logic [31:0] wb_dat [2];
   logic        wb_we  [2];
   logic [3:0]  wb_sel [2];
   logic        wb_stb [2];
   logic        wb_cyc [2];
   logic        probe  [2];

   logic [31:0] dat_o_a, dat_o_b;
   logic        ack_a, ack_b, err_a, err_b;
   logic [19:0] addr_a, addr_b;
   wire  [31:0] sram_data_a, sram_data_b;
   logic [1:0]  ce_n_a;
   logic [2:0]  ce_n_b;
   logic        oe_n_a, oe_n_b, we_n_a, we_n_b;
   logic [3:0]  be_n_a, be_n_b;

   sram_multibank_controller dut_a (
      .clk_i(clk), .rst_ni(rst_n),
      .wb_adr_i(wb_adr[0]), .wb_dat_i(wb_dat[0]), .wb_dat_o(dat_o_a), .wb_we_i(wb_we[0]),
      .wb_sel_i(wb_sel[0]), .wb_stb_i(wb_stb[0]), .wb_cyc_i(wb_cyc[0]),
      .wb_ack_o(ack_a), .wb_err_o(err_a),
      .sram_addr(addr_a), .sram_data(sram_data_a), .sram_ce_n(ce_n_a),
      .sram_oe_n(oe_n_a), .sram_we_n(we_n_a), .sram_be_n(be_n_a)
   );

   sram_multibank_controller #(
      .NUM_BANKS(3), .READ_WAIT(4), .WR_SETUP(2), .WR_PULSE(3)
   ) dut_b (
      .clk_i(clk), .rst_ni(rst_n),
      .wb_adr_i(wb_adr[1]), .wb_dat_i(wb_dat[1]), .wb_dat_o(dat_o_b), .wb_we_i(wb_we[1]),
      .wb_sel_i(wb_sel[1]), .wb_stb_i(wb_stb[1]), .wb_cyc_i(wb_cyc[1]),
      .wb_ack_o(ack_b), .wb_err_o(err_b),
      .sram_addr(addr_b), .sram_data(sram_data_b), .sram_ce_n(ce_n_b),
      .sram_oe_n(oe_n_b), .sram_we_n(we_n_b), .sram_be_n(be_n_b)
   );

   // Uniform per-instance views so tasks can take an instance index.
   logic        ack_v [2], err_v [2], oe_n_v [2], we_n_v [2];
   logic [31:0] dat_o_v [2];
   logic [19:0] addr_v [2];
   logic [2:0]  ce_v [2];
   logic [3:0]  be_v [2];
   assign ack_v[0] = ack_a;           assign ack_v[1] = ack_b;
   assign err_v[0] = err_a;           assign err_v[1] = err_b;
   assign oe_n_v[0] = oe_n_a;         assign oe_n_v[1] = oe_n_b;
   assign we_n_v[0] = we_n_a;         assign we_n_v[1] = we_n_b;
   assign dat_o_v[0] = dat_o_a;       assign dat_o_v[1] = dat_o_b;
   assign addr_v[0] = addr_a;         assign addr_v[1] = addr_b;
   assign ce_v[0] = {1'b1, ce_n_a};   assign ce_v[1] = ce_n_b;
   assign be_v[0] = be_n_a;           assign be_v[1] = be_n_b;

   localparam int RW_P [2] = '{2, 4};
   localparam int WS_P [2] = '{1, 2};
   localparam int WP_P [2] = '{1, 3};
   localparam int NB_P [2] = '{2, 3};

   function automatic logic [31:0] initWord(int b, int w);
      return 32'h5A00_0000 | (32'(b) << 16) | 32'(w);
   endfunction

   function automatic logic [31:0] mergeBytes(logic [31:0] old, logic [31:0] nw, logic [3:0] be_n);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) begin
         if (!be_n[i]) r[8*i +: 8] = nw[8*i +: 8];
      end
      return r;
   endfunction

   // SRAM chip models: drive the selected word while CE and OE are low, write masked bytes while WE is low.
   logic [31:0] mem_a [4][256];
   logic [31:0] mem_b [4][256];
   logic [31:0] shadow [2][4][256];
   logic [1:0]  rd_bank_a, rd_bank_b;

   always_comb begin
      rd_bank_a = 2'd0;
      rd_bank_b = 2'd0;
      for (int b = 0; b < 2; b++) if (ce_n_a[b] == 1'b0) rd_bank_a = 2'(b);
      for (int b = 0; b < 3; b++) if (ce_n_b[b] == 1'b0) rd_bank_b = 2'(b);
   end

   assign sram_data_a = probe[0] ? 32'h0 :
                        (oe_n_a == 1'b0 && ce_n_a != 2'b11) ? mem_a[rd_bank_a][addr_a[7:0]] : 32'bz;
   assign sram_data_b = probe[1] ? 32'h0 :
                        (oe_n_b == 1'b0 && ce_n_b != 3'b111) ? mem_b[rd_bank_b][addr_b[7:0]] : 32'bz;

   always @(negedge clk) begin
      if (we_n_a == 1'b0) begin
         for (int b = 0; b < 2; b++)
            if (ce_n_a[b] == 1'b0)
               mem_a[b][addr_a[7:0]] <= mergeBytes(mem_a[b][addr_a[7:0]], sram_data_a, be_n_a);
      end
      if (we_n_b == 1'b0) begin
         for (int b = 0; b < 3; b++)
            if (ce_n_b[b] == 1'b0)
               mem_b[b][addr_b[7:0]] <= mergeBytes(mem_b[b][addr_b[7:0]], sram_data_b, be_n_b);
      end
   end

   int total = 0;
   int bad   = 0;

   typedef struct {
      int          inst;
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      int          exp_resp;
      int          exp_lat;
      logic [31:0] exp_data;
      logic [2:0]  exp_ce;
      logic [19:0] exp_addr;
      logic [3:0]  exp_be;
      int          exp_we_first;
      int          exp_we_cnt;
   } vec_t;

   vec_t vecs [13];

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got=%0h expected=%0h", name, actual, expected);
      end
   endtask

   // One Wishbone access; samples outputs half a cycle after every edge following E0.
   task automatic applyStimulus(input int inst, input logic we, input logic [31:0] adr,
                                input logic [31:0] dat, input logic [3:0] sel, input int drop_at,
                                output int resp, output int lat, output logic [31:0] rdata,
                                output logic [2:0] ce0, output logic [19:0] addr0, output logic [3:0] be0,
                                output int we_first, output int we_cnt, output logic inv_bad);
      resp = 0; lat = -1; rdata = '0; ce0 = '1; addr0 = '0; be0 = '1;
      we_first = -1; we_cnt = 0; inv_bad = 1'b0;
      @(negedge clk);
      wb_adr[inst] = adr; wb_dat[inst] = dat; wb_we[inst] = we; wb_sel[inst] = sel;
      wb_stb[inst] = 1'b1; wb_cyc[inst] = 1'b1;
      for (int k = 0; k < 24; k++) begin
         @(negedge clk);
         if (k == 0) begin
            ce0 = ce_v[inst]; addr0 = addr_v[inst]; be0 = be_v[inst];
         end
         if (we_n_v[inst] == 1'b0) begin
            if (we_first < 0) we_first = k;
            we_cnt++;
         end
         if ($countones(~ce_v[inst]) > 1 || (oe_n_v[inst] == 1'b0 && we_n_v[inst] == 1'b0)) inv_bad = 1'b1;
         if (resp != 0) begin
            checkOutput($sformatf("inst%0d.pulse_end", inst), {ack_v[inst], err_v[inst]}, 2'b00);
            break;
         end
         if (ack_v[inst] || err_v[inst]) begin
            resp  = ack_v[inst] ? 1 : 2;
            lat   = k;
            rdata = dat_o_v[inst];
            wb_stb[inst] = 1'b0; wb_cyc[inst] = 1'b0;
         end
         if (k == drop_at) begin
            wb_stb[inst] = 1'b0; wb_cyc[inst] = 1'b0;
         end
      end
      wb_stb[inst] = 1'b0; wb_cyc[inst] = 1'b0;
   endtask

   task automatic runVector(input vec_t v, input string tag);
      int resp, lat, wf, wc, bank, word;
      logic [31:0] rd;
      logic [2:0] ce0;
      logic [19:0] a0;
      logic [3:0] be0;
      logic inv;
      applyStimulus(v.inst, v.we, v.adr, v.dat, v.sel, -1, resp, lat, rd, ce0, a0, be0, wf, wc, inv);
      checkOutput({tag, ".resp"}, resp, v.exp_resp);
      checkOutput({tag, ".lat"}, lat, v.exp_lat);
      checkOutput({tag, ".ce_n"}, ce0, v.exp_ce);
      checkOutput({tag, ".be_n"}, be0, v.exp_be);
      checkOutput({tag, ".we_first"}, wf, v.exp_we_first);
      checkOutput({tag, ".we_cnt"}, wc, v.exp_we_cnt);
      checkOutput({tag, ".bus_rules"}, inv, 1'b0);
      if (v.exp_resp == 1) checkOutput({tag, ".addr"}, a0, v.exp_addr);
      if (v.exp_resp == 1 && !v.we) checkOutput({tag, ".rdata"}, rd, v.exp_data);
      if (v.exp_resp == 1 && v.we) begin
         bank = (v.inst == 0) ? int'(v.adr[22]) : int'(v.adr[23:22]);
         word = int'(v.adr[9:2]);
         shadow[v.inst][bank][word] = mergeBytes(shadow[v.inst][bank][word], v.dat, ~v.sel);
      end
   endtask

   task automatic runRandom(input int count);
      vec_t v;
      int bank, word, ok;
      for (int n = 0; n < count; n++) begin
         v.inst = $urandom_range(0, 1);
         bank   = (v.inst == 0) ? $urandom_range(0, 1) : $urandom_range(0, 3);
         word   = $urandom_range(0, 15);
         v.we   = 1'($urandom_range(0, 1));
         v.sel  = 4'($urandom_range(1, 15));
         v.dat  = $urandom;
         v.adr  = $urandom;
         v.adr[21:0] = {20'(word), 2'($urandom_range(0, 3))};
         if (v.inst == 0) v.adr[22] = 1'(bank);
         else v.adr[23:22] = 2'(bank);
         ok = (bank < NB_P[v.inst]) ? 1 : 0;
         v.exp_resp     = ok ? 1 : 2;
         v.exp_lat      = !ok ? 0 : (v.we ? WS_P[v.inst] + WP_P[v.inst] + 1 : RW_P[v.inst]);
         v.exp_data     = (ok && !v.we) ? shadow[v.inst][bank][word] : 32'h0;
         v.exp_ce       = 3'b111;
         if (ok) v.exp_ce[bank] = 1'b0;
         v.exp_addr     = 20'(word);
         v.exp_be       = ok ? ~v.sel : 4'hF;
         v.exp_we_first = (ok && v.we) ? WS_P[v.inst] : -1;
         v.exp_we_cnt   = (ok && v.we) ? WP_P[v.inst] : 0;
         runVector(v, $sformatf("rnd%0d", n));
      end
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1);
   end

   initial begin
      int resp, lat, wf, wc;
      logic [31:0] rd, prev_dat;
      logic [2:0] ce0;
      logic [19:0] a0;
      logic [3:0] be0;
      logic inv, saw;

      for (int i = 0; i < 2; i++)
         for (int b = 0; b < 4; b++)
            for (int w = 0; w < 256; w++) begin
               shadow[i][b][w] = initWord(b, w);
               if (i == 0) mem_a[b][w] = initWord(b, w);
               else mem_b[b][w] = initWord(b, w);
            end

      //                inst we    adr            dat            sel      rsp lat data           ce      addr    be      wf  wc
      vecs[0]  = '{0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF,    1, 3, 32'h0,         3'b110, 20'h4, 4'h0,    1, 1};
      vecs[1]  = '{0, 1'b0, 32'h0000_0010, 32'h0,         4'hF,    1, 2, 32'hDEAD_BEEF, 3'b110, 20'h4, 4'h0,   -1, 0};
      vecs[2]  = '{0, 1'b1, 32'h0040_0003, 32'hAA00_0000, 4'b1000, 1, 3, 32'h0,         3'b101, 20'h0, 4'b0111, 1, 1};
      vecs[3]  = '{0, 1'b0, 32'h0040_0000, 32'h0,         4'hF,    1, 2, 32'hAA01_0000, 3'b101, 20'h0, 4'h0,   -1, 0};
      vecs[4]  = '{0, 1'b0, 32'h0000_0000, 32'h0,         4'hF,    1, 2, 32'h5A00_0000, 3'b110, 20'h0, 4'h0,   -1, 0};
      vecs[5]  = '{0, 1'b1, 32'hFF80_0010, 32'h0BAD_F00D, 4'b0001, 1, 3, 32'h0,         3'b110, 20'h4, 4'b1110, 1, 1};
      vecs[6]  = '{0, 1'b0, 32'h7F00_0011, 32'h0,         4'hF,    1, 2, 32'hDEAD_BE0D, 3'b110, 20'h4, 4'h0,   -1, 0};
      vecs[7]  = '{1, 1'b0, 32'h00C0_0000, 32'h0,         4'hF,    2, 0, 32'h0,         3'b111, 20'h0, 4'hF,   -1, 0};
      vecs[8]  = '{1, 1'b0, 32'h0000_0008, 32'h0,         4'hF,    1, 4, 32'h5A00_0002, 3'b110, 20'h2, 4'h0,   -1, 0};
      vecs[9]  = '{1, 1'b1, 32'h0080_0014, 32'h1234_5678, 4'hF,    1, 6, 32'h0,         3'b011, 20'h5, 4'h0,    2, 3};
      vecs[10] = '{1, 1'b0, 32'h0080_0014, 32'h0,         4'b0011, 1, 4, 32'h1234_5678, 3'b011, 20'h5, 4'b1100,-1, 0};
      vecs[11] = '{1, 1'b1, 32'h0040_0008, 32'h00C3_0000, 4'b0100, 1, 6, 32'h0,         3'b101, 20'h2, 4'b1011, 2, 3};
      vecs[12] = '{1, 1'b0, 32'h0040_0008, 32'h0,         4'hF,    1, 4, 32'h5AC3_0002, 3'b101, 20'h2, 4'h0,   -1, 0};

      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         wb_adr[i] = '0; wb_dat[i] = '0; wb_we[i] = 1'b0; wb_sel[i] = '0;
         wb_stb[i] = 1'b0; wb_cyc[i] = 1'b0; probe[i] = 1'b0;
      end

      // Reset held across two edges while the bus side is driven with noise.
      repeat (2) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            wb_adr[i] = $urandom; wb_dat[i] = $urandom; wb_we[i] = 1'($urandom);
            wb_sel[i] = 4'($urandom); wb_stb[i] = 1'b1; wb_cyc[i] = 1'b1;
         end
      end
      @(negedge clk);
      probe[0] = 1'b1; probe[1] = 1'b1;
      #1;
      checkOutput("rst.ack_a", ack_a, 1'b0);
      checkOutput("rst.err_a", err_a, 1'b0);
      checkOutput("rst.dat_o_a", dat_o_a, 32'h0);
      checkOutput("rst.addr_a", addr_a, 20'h0);
      checkOutput("rst.ce_n_a", ce_n_a, 2'b11);
      checkOutput("rst.oe_n_a", oe_n_a, 1'b1);
      checkOutput("rst.we_n_a", we_n_a, 1'b1);
      checkOutput("rst.be_n_a", be_n_a, 4'hF);
      checkOutput("rst.data_hiz_a", sram_data_a, 32'h0);
      checkOutput("rst.ack_err_b", {ack_b, err_b}, 2'b00);
      checkOutput("rst.ce_n_b", ce_n_b, 3'b111);
      checkOutput("rst.data_hiz_b", sram_data_b, 32'h0);
      probe[0] = 1'b0; probe[1] = 1'b0;
      for (int i = 0; i < 2; i++) begin
         wb_stb[i] = 1'b0; wb_cyc[i] = 1'b0;
      end
      rst_n = 1'b1;

      for (int i = 0; i < 13; i++) runVector(vecs[i], $sformatf("vec%0d", i));

      // Read abandoned by the master right after E0: the chip sequence finishes but nothing is acked.
      prev_dat = dat_o_b;
      applyStimulus(1, 1'b0, 32'h0000_001C, 32'h0, 4'hF, 0, resp, lat, rd, ce0, a0, be0, wf, wc, inv);
      checkOutput("abort.no_ack", resp, 0);
      checkOutput("abort.dat_o_kept", dat_o_b, prev_dat);
      applyStimulus(1, 1'b0, 32'h0000_001C, 32'h0, 4'hF, -1, resp, lat, rd, ce0, a0, be0, wf, wc, inv);
      checkOutput("abort.next_resp", resp, 1);
      checkOutput("abort.next_lat", lat, 4);
      checkOutput("abort.next_data", rd, 32'h5A00_0007);

      // Reset asserted while WE is low on instance B.
      @(negedge clk);
      wb_adr[1] = 32'h0040_0320; wb_dat[1] = 32'hCAFE_0001; wb_we[1] = 1'b1; wb_sel[1] = 4'hF;
      wb_stb[1] = 1'b1; wb_cyc[1] = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("midrst.we_low", we_n_b, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      probe[1] = 1'b1;
      #1;
      checkOutput("midrst.we_n", we_n_b, 1'b1);
      checkOutput("midrst.ce_n", ce_n_b, 3'b111);
      checkOutput("midrst.data_hiz", sram_data_b, 32'h0);
      checkOutput("midrst.ack", ack_b, 1'b0);
      probe[1] = 1'b0;
      wb_stb[1] = 1'b0; wb_cyc[1] = 1'b0;
      rst_n = 1'b1;
      saw = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (ack_b || err_b) saw = 1'b1;
      end
      checkOutput("midrst.no_late_ack", saw, 1'b0);

      runRandom(40);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
